rgb_upsampler: RTL and testbench

RGB_UPSAMPLER -- requirements
Module: rgb_upsampler

---
 rtl/rgb_upsampler.sv | 148 ++++++++++++++
 tb/tb_rgb_upsampler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rgb_upsampler.sv
// Expands 8-bit R/G/B to 10 bits (OUT = (IN*1023 + bias)/255) using one shared
// serial restoring divider that produces one quotient bit per cycle, channels in R, G, B order.
module rgb_upsampler #(
  parameter int unsigned ROUND = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] VGA_R_In,
  input  logic [7:0] VGA_G_In,
  input  logic [7:0] VGA_B_In,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [9:0] VGA_R_Out,
  output logic [9:0] VGA_G_Out,
  output logic [9:0] VGA_B_Out,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam logic [17:0] Bias = (ROUND != 0) ? 18'd127 : 18'd0;

  typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pix_r_q, pix_r_d, pix_g_q, pix_g_d, pix_b_q, pix_b_d;
  logic [1:0]  chan_q, chan_d;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  rem_q, rem_d;
  logic [9:0]  quo_r_q, quo_r_d, quo_g_q, quo_g_d, quo_b_q, quo_b_d;
  logic [9:0]  out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;

  logic [7:0]  cur_pix;
  logic [17:0] dividend;
  logic [9:0]  div_low;
  logic [8:0]  rem_cur, trial, rem_next;
  logic        q_bit;

  // Divider datapath for the channel and bit currently selected by the counters
  always_comb begin
    cur_pix = pix_b_q;
    case (chan_q)
      2'd0:    cur_pix = pix_r_q;
      2'd1:    cur_pix = pix_g_q;
      default: cur_pix = pix_b_q;
    endcase
    dividend = ({10'd0, cur_pix} << 10) - {10'd0, cur_pix} + Bias;
    div_low  = dividend[9:0];
    // A new channel starts from the top dividend bits instead of the stored remainder
    rem_cur  = (bit_q == 4'd9) ? {1'b0, dividend[17:10]} : rem_q;
    trial    = {rem_cur[7:0], div_low[bit_q]};
    q_bit    = (trial >= 9'd255);
    rem_next = q_bit ? (trial - 9'd255) : trial;
  end

  always_comb begin
    state_d = state_q;
    pix_r_d = pix_r_q;
    pix_g_d = pix_g_q;
    pix_b_d = pix_b_q;
    chan_d  = chan_q;
    bit_d   = bit_q;
    rem_d   = rem_q;
    quo_r_d = quo_r_q;
    quo_g_d = quo_g_q;
    quo_b_d = quo_b_q;
    out_r_d = out_r_q;
    out_g_d = out_g_q;
    out_b_d = out_b_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StDiv;
          pix_r_d = VGA_R_In;
          pix_g_d = VGA_G_In;
          pix_b_d = VGA_B_In;
          chan_d  = 2'd0;
          bit_d   = 4'd9;
          rem_d   = 9'd0;
        end
      end
      StDiv: begin
        rem_d = rem_next;
        case (chan_q)
          2'd0:    quo_r_d = {quo_r_q[8:0], q_bit};
          2'd1:    quo_g_d = {quo_g_q[8:0], q_bit};
          default: quo_b_d = {quo_b_q[8:0], q_bit};
        endcase
        if (bit_q == 4'd0) begin
          bit_d = 4'd9;
          if (chan_q == 2'd2) begin
            state_d = StDone;
            out_r_d = quo_r_q;
            out_g_d = quo_g_q;
            out_b_d = {quo_b_q[8:0], q_bit};
          end else begin
            chan_d = chan_q + 2'd1;
          end
        end else begin
          bit_d = bit_q - 4'd1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
      pix_r_q <= 8'd0;
      pix_g_q <= 8'd0;
      pix_b_q <= 8'd0;
      chan_q  <= 2'd0;
      bit_q   <= 4'd0;
      rem_q   <= 9'd0;
      quo_r_q <= 10'd0;
      quo_g_q <= 10'd0;
      quo_b_q <= 10'd0;
      out_r_q <= 10'd0;
      out_g_q <= 10'd0;
      out_b_q <= 10'd0;
    end else begin
      state_q <= state_d;
      pix_r_q <= pix_r_d;
      pix_g_q <= pix_g_d;
      pix_b_q <= pix_b_d;
      chan_q  <= chan_d;
      bit_q   <= bit_d;
      rem_q   <= rem_d;
      quo_r_q <= quo_r_d;
      quo_g_q <= quo_g_d;
      quo_b_q <= quo_b_d;
      out_r_q <= out_r_d;
      out_g_q <= out_g_d;
      out_b_q <= out_b_d;
    end
  end

  // in_ready is held low for as long as reset is applied
  assign in_ready  = (state_q == StIdle) & Reset_n;
  assign out_valid = (state_q == StDone);
  assign VGA_R_Out = out_r_q;
  assign VGA_G_Out = out_g_q;
  assign VGA_B_Out = out_b_q;

endmodule

// File: tb/tb_rgb_upsampler.sv
// Directed bench for rgb_upsampler: one instance per rounding mode, driven in lockstep.
module tb_rgb_upsampler;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] in_r, in_g, in_b;
  logic       in_valid, out_ready;

  logic       r1_ir, r1_ov, r0_ir, r0_ov;
  logic [9:0] r1_r, r1_g, r1_b, r0_r, r0_g, r0_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_edge, prev_edge, xfer_edge;

  always #5 Clk = ~Clk;

  rgb_upsampler #(.ROUND(1)) u_r1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .VGA_R_In(in_r), .VGA_G_In(in_g), .VGA_B_In(in_b),
    .in_valid(in_valid), .in_ready(r1_ir),
    .VGA_R_Out(r1_r), .VGA_G_Out(r1_g), .VGA_B_Out(r1_b),
    .out_valid(r1_ov), .out_ready(out_ready)
  );

  rgb_upsampler #(.ROUND(0)) u_r0 (
    .Clk(Clk), .Reset_n(Reset_n),
    .VGA_R_In(in_r), .VGA_G_In(in_g), .VGA_B_In(in_b),
    .in_valid(in_valid), .in_ready(r0_ir),
    .VGA_R_Out(r0_r), .VGA_G_Out(r0_g), .VGA_B_Out(r0_b),
    .out_valid(r0_ov), .out_ready(out_ready)
  );

  typedef struct {
    logic [23:0] px;
    logic [29:0] e1;
    logic [29:0] e0;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [9:0] model(input int v, input int rnd);
    return 10'((v * 1023 + ((rnd != 0) ? 127 : 0)) / 255);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input int bound);
    int k = 0;
    while (!r1_ir && k < bound) begin
      tick();
      k++;
    end
    check("in_ready wait", {31'd0, r1_ir}, 32'd1);
  endtask

  // Presents px, waits for the accept edge, then checks latency and both results
  task automatic do_pixel(input string name, input logic [23:0] px, input logic [29:0] e1,
                          input logic [29:0] e0, input bit hold_valid);
    {in_r, in_g, in_b} = px;
    in_valid = 1'b1;
    wait_ready(40);
    acc_edge = cyc + 1;
    tick();
    if (!hold_valid) in_valid = 1'b0;
    repeat (29) tick();
    check({name, " early valid"}, {30'd0, r1_ov, r0_ov}, 32'd0);
    tick();
    check({name, " valid"}, {30'd0, r1_ov, r0_ov}, 32'd3);
    check({name, " out r1"}, {2'd0, r1_r, r1_g, r1_b}, {2'd0, e1});
    check({name, " out r0"}, {2'd0, r0_r, r0_g, r0_b}, {2'd0, e0});
  endtask

  initial begin
    logic [29:0] held;
    vecs[0] = '{{8'd0, 8'd128, 8'd255}, {10'd0, 10'd514, 10'd1023}, {10'd0, 10'd513, 10'd1023}};
    vecs[1] = '{{8'd1, 8'd2, 8'd254}, {10'd4, 10'd8, 10'd1019}, {10'd4, 10'd8, 10'd1018}};
    vecs[2] = '{{8'd64, 8'd100, 8'd200}, {10'd257, 10'd401, 10'd802},
                {10'd256, 10'd401, 10'd802}};
    vecs[3] = '{{8'd255, 8'd0, 8'd17}, {10'd1023, 10'd0, 10'd68}, {10'd1023, 10'd0, 10'd68}};
    vecs[4] = '{{8'd128, 8'd128, 8'd128}, {10'd514, 10'd514, 10'd514},
                {10'd513, 10'd513, 10'd513}};

    in_r = 8'd0; in_g = 8'd0; in_b = 8'd0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    Reset_n = 1'b1;
    #2 Reset_n = 1'b0;
    #2;
    check("reset flags", {28'd0, r1_ir, r1_ov, r0_ir, r0_ov}, 32'd0);
    check("reset outs", {2'd0, r1_r, r1_g, r1_b} | {2'd0, r0_r, r0_g, r0_b}, 32'd0);
    tick();
    tick();
    Reset_n = 1'b1;
    #1;
    check("ready after reset", {30'd0, r1_ir, r0_ir}, 32'd3);

    // Table of directed pixels, each followed by a one-cycle pulse check
    for (int i = 0; i < 5; i++) begin
      do_pixel($sformatf("vec%0d", i), vecs[i].px, vecs[i].e1, vecs[i].e0, 1'b0);
      tick();
      check($sformatf("vec%0d pulse", i), {30'd0, r1_ov, r1_ir}, 32'd1);
    end

    // A valid glitch between edges must not start a transaction
    in_valid = 1'b1;
    #2 in_valid = 1'b0;
    repeat (35) tick();
    check("glitch ignored", {30'd0, r1_ov, r1_ir}, 32'd1);

    // Downstream stall with a competing pixel offered meanwhile
    out_ready = 1'b0;
    do_pixel("stall", vecs[2].px, vecs[2].e1, vecs[2].e0, 1'b0);
    held = {r1_r, r1_g, r1_b};
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        {in_r, in_g, in_b} = {8'd17, 8'd34, 8'd51};
        in_valid = 1'b1;
      end
      if (k == 6) in_valid = 1'b0;
      tick();
      check($sformatf("stall%0d flags", k), {30'd0, r1_ov, r1_ir}, 32'd2);
      check($sformatf("stall%0d outs", k), {2'd0, r1_r, r1_g, r1_b}, {2'd0, held});
    end
    {in_r, in_g, in_b} = vecs[3].px;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    xfer_edge = cyc;
    check("xfer flags", {30'd0, r1_ov, r1_ir}, 32'd1);
    check("retain outs", {2'd0, r1_r, r1_g, r1_b}, {2'd0, held});
    do_pixel("after stall", vecs[3].px, vecs[3].e1, vecs[3].e0, 1'b0);
    check("accept after xfer", acc_edge, xfer_edge + 1);
    tick();

    // Reset in the middle of the G channel
    {in_r, in_g, in_b} = {8'd10, 8'd20, 8'd30};
    in_valid = 1'b1;
    wait_ready(40);
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    Reset_n = 1'b0;
    #1;
    check("mid reset flags", {28'd0, r1_ir, r1_ov, r0_ir, r0_ov}, 32'd0);
    check("mid reset outs r1", {2'd0, r1_r, r1_g, r1_b}, 32'd0);
    check("mid reset outs r0", {2'd0, r0_r, r0_g, r0_b}, 32'd0);
    tick();
    tick();
    check("held reset outs", {2'd0, r1_r, r1_g, r1_b}, 32'd0);
    Reset_n = 1'b1;
    #1;
    check("ready after mid reset", {31'd0, r1_ir}, 32'd1);
    do_pixel("post reset", {8'd255, 8'd255, 8'd255}, {3{10'd1023}}, {3{10'd1023}}, 1'b0);
    tick();

    // Back-to-back sweep: every value on every channel, accepts 32 cycles apart
    in_valid = 1'b1;
    out_ready = 1'b1;
    prev_edge = 0;
    for (int i = 0; i < 256; i++) begin
      int g, b;
      g = (i + 85) % 256;
      b = (i + 170) % 256;
      do_pixel($sformatf("sweep%0d", i), {8'(i), 8'(g), 8'(b)},
               {model(i, 1), model(g, 1), model(b, 1)},
               {model(i, 0), model(g, 0), model(b, 0)}, 1'b1);
      if (i > 0) check($sformatf("spacing%0d", i), acc_edge - prev_edge, 32);
      prev_edge = acc_edge;
    end
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
